// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/valid
// handshake and presents it to decode. Optional WAIT timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_plus4_reg, pc_plus4_next;
    logic        instr_valid_reg, instr_valid_next;
    logic [31:0] retire_pc;
    logic        timeout_hit;

    // Target selection for the retiring instruction; jump outranks a taken branch.
    always_comb begin
        retire_pc = pc_plus4_reg;
        if (jump) begin
            retire_pc = {pc_plus4_reg[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            retire_pc = pc_plus4_reg + (branch_offset << 2);
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        pc_plus4_next    = pc_plus4_reg;
        instr_valid_next = instr_valid_reg;
        case (state_reg)
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    instr_next       = imem_data;
                    pc_plus4_next    = pc_reg + 32'd4;
                    instr_valid_next = 1'b1;
                    state_next       = S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    instr_valid_next = 1'b0;
                    pc_next          = retire_pc;
                    state_next       = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_FETCH;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'd0;
            pc_plus4_reg    <= RESET_PC + 32'd4;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            pc_plus4_reg    <= pc_plus4_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             fetch_err_reg;

    // A response in the expiring cycle takes precedence over the timeout.
    assign timeout_hit = (state_reg == S_WAIT) && !imem_valid &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_next = '0;
        if (state_reg == S_WAIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg  <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (timeout_hit) begin
                fetch_err_reg <= 1'b1;
            end
        end
    end

    assign fetch_err = fetch_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // Request is masked while reset is held so it reads 0 during reset.
    assign imem_req    = (state_reg == S_FETCH) && !reset;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[31:26];
    assign pc_plus4    = pc_plus4_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, next-PC selection, stall hold,
// reset in WAIT/ISSUE, PC wrap and (with FETCH_TIMEOUT_EN) the WAIT timeout.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, zero, jump;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(
        .RESET_PC(32'h00000000),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .branch_offset(branch_offset),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .instr        (instr),
        .op           (op),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Called at a negedge; returns at the negedge of the FETCH cycle (bounded).
    task automatic wait_req();
        int n = 0;
        #1;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!imem_req) check("req_seen", 32'(imem_req), 32'd1);
    endtask

    // Fetch with a one-cycle response; ends at the negedge of the ISSUE cycle.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
        logic [31:0] exp_op;
        exp_op = data >> 26;
        wait_req();
        check("req_addr", imem_addr, exp_addr);
        @(negedge clk);
        imem_valid = 1'b1;
        imem_data  = data;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        check("instr", instr, data);
        check("op", 32'(op), exp_op);
        check("pc_plus4", pc_plus4, exp_addr + 32'd4);
        check("instr_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic retire(input logic j, input logic b, input logic z,
                          input logic [31:0] off, input logic [25:0] tgt);
        stall = 1'b0; jump = j; branch = b; zero = z;
        branch_offset = off; jump_target = tgt;
        @(negedge clk);
        stall = 1'b1; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        branch_offset = 32'h0; jump_target = 26'h0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        branch_offset = 32'h0; jump_target = 26'h0; imem_valid = 1'b0; imem_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_err", 32'(fetch_err), 32'd0);
        reset = 1'b0;

        // First fetch, then sequential next request
        fetch_one(32'h0, 32'h8C080004);
        check("op_lw", 32'(op), 32'h23);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch_one(32'h4, 32'h08000004);
        retire(1'b1, 1'b0, 1'b0, 32'h0, 26'h4);
        // beq at 0x10 taken backwards
        fetch_one(32'h10, 32'h1000FFFF);
        retire(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 26'h0);
        fetch_one(32'h4, 32'h08000004);
        retire(1'b1, 1'b0, 1'b0, 32'h0, 26'h4);
        // beq at 0x10 not taken
        fetch_one(32'h10, 32'h1000FFFF);
        retire(1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 26'h0);
        fetch_one(32'h14, 32'h1000FFFF);
        retire(1'b0, 1'b1, 1'b1, 32'h0FFFFFFA, 26'h0);
        // j at 0x40000000, with a stall hold first
        fetch_one(32'h40000000, 32'h08000010);
        for (int i = 0; i < 5; i++) begin
            branch = i[0]; jump = i[1]; zero = 1'b1; jump_target = 26'h3FFFFFF;
            @(negedge clk);
            #1;
            check("stall_instr", instr, 32'h08000010);
            check("stall_pc4", pc_plus4, 32'h40000004);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        retire(1'b1, 1'b0, 1'b0, 32'h0, 26'h0000010);
        fetch_one(32'h40000040, 32'h08000020);
        // jump and taken branch together: jump wins
        retire(1'b1, 1'b1, 1'b1, 32'h00000100, 26'h0000020);
        fetch_one(32'h40000080, 32'h00000000);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        fetch_one(32'h40000084, 32'h10000000);
        // branch that wraps through 2^32 to land on 0x20
        retire(1'b0, 1'b1, 1'b1, 32'h2FFFFFE6, 26'h0);

        // Reset while waiting on the fetch at 0x20
        wait_req();
        check("req_addr_20", imem_addr, 32'h20);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rstw_valid", 32'(instr_valid), 32'd0);
        check("rstw_addr", imem_addr, 32'h0);
        check("rstw_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 32'hDEADBEEF;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        #1;
        check("spurious_ignored", 32'(instr_valid), 32'd0);
        imem_valid = 1'b1;
        imem_data  = 32'h8C080004;
        @(negedge clk);
        imem_valid = 1'b0;
        check("after_spurious", instr, 32'h8C080004);

        // Reset during ISSUE drops the instruction
        reset = 1'b1;
        @(negedge clk);
        check("rsti_valid", 32'(instr_valid), 32'd0);
        check("rsti_instr", instr, 32'h0);
        reset = 1'b0;

        // PC+4 wraps at the top of the address space
        fetch_one(32'h0, 32'h10000000);
        retire(1'b0, 1'b1, 1'b1, 32'h3FFFFFFE, 26'h0);
        fetch_one(32'hFFFFFFFC, 32'h00000000);
        check("wrap_pc4", pc_plus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        wait_req();
        check("wrap_addr", imem_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        // Response on the 4th WAIT cycle beats the timeout
        wait_req();
        repeat (4) @(negedge clk);
        imem_valid = 1'b1;
        imem_data  = 32'h8C080004;
        @(negedge clk);
        imem_valid = 1'b0;
        check("late_rsp_valid", 32'(instr_valid), 32'd1);
        check("late_rsp_err", 32'(fetch_err), 32'd0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        // No response: timeout and re-request the same address
        wait_req();
        check("to_addr", imem_addr, 32'h4);
        repeat (4) @(negedge clk);
        #1;
        check("to_err_before", 32'(fetch_err), 32'd0);
        check("to_req_before", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_rereq", 32'(imem_req), 32'd1);
        check("to_readdr", imem_addr, 32'h4);
        fetch_one(32'h4, 32'h00000000);
        check("to_sticky", 32'(fetch_err), 32'd1);
`else
        // Without the timeout, WAIT holds indefinitely
        @(negedge clk);
        repeat (20) @(negedge clk);
        #1;
        check("nto_req", 32'(imem_req), 32'd0);
        check("nto_err", 32'(fetch_err), 32'd0);
        check("nto_valid", 32'(instr_valid), 32'd0);
        imem_valid = 1'b1;
        imem_data  = 32'h12345678;
        @(negedge clk);
        imem_valid = 1'b0;
        check("nto_instr", instr, 32'h12345678);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
